// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and payload types for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] PCSEL_PLUS4 = 2'd0;
  localparam logic [1:0] PCSEL_ALU   = 2'd1;
  localparam logic [1:0] PCSEL_SAME  = 2'd2;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_2000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  // Instruction word as presented to decode; valid=0 marks an injected bubble.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic            valid;
  } fetch_word_t;

  // Redirect targets are word-aligned by dropping the two low bits.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] target);
    return target & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC priority mux, PC register and the stalled-redirect latch.
module fetch_pc_gen
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            boot,
  input  logic            stall,
  input  logic [1:0]      pc_sel,
  input  logic            inst_kill,
  input  logic [XLEN-1:0] alu_target,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_q
);

  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] redir_q;
  logic            redir_pend;
  logic            redir_capture;

  assign tgt           = align_target(alu_target);
  assign redir_capture = stall && inst_kill && (pc_sel == PCSEL_ALU);

  // Boot and stall dominate; a redirect remembered across a stall beats the live select.
  always_comb begin
    pc_next = pc_q + XLEN'(4);
    if (boot) begin
      pc_next = RESET_PC;
    end else if (stall) begin
      pc_next = pc_q;
    end else if (redir_pend) begin
      pc_next = redir_q;
    end else if (pc_sel == PCSEL_ALU) begin
      pc_next = tgt;
    end else if (pc_sel == PCSEL_SAME) begin
      pc_next = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  // Latest redirect seen during a stall wins; consumed on the first unstalled cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redir_q    <= '0;
      redir_pend <= 1'b0;
    end else if (redir_capture) begin
      redir_q    <= tgt;
      redir_pend <= 1'b1;
    end else if (!stall) begin
      redir_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, I-cache request, stall hold buffer and bubble injection.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [1:0]      pc_sel,
  input  logic            inst_kill,
  input  logic [XLEN-1:0] alu_target,
  output logic [XLEN-1:0] icache_addr,
  output logic            icache_re,
  input  logic [XLEN-1:0] icache_dout,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] inst_out,
  output logic            inst_valid
);

  fetch_state_e state_q, state_d;
  fetch_word_t  hold_q, hold_d;
  fetch_word_t  word;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_q;

  fetch_pc_gen u_pc_gen (
    .clk        (clk),
    .reset      (reset),
    .boot       (state_q == FETCH_BOOT),
    .stall      (stall),
    .pc_sel     (pc_sel),
    .inst_kill  (inst_kill),
    .alu_target (alu_target),
    .pc_next    (pc_next),
    .pc_q       (pc_q)
  );

  assign icache_addr = pc_next;
  assign icache_re   = reset;
  assign pc_f        = pc_q;
  assign inst_out    = word.inst;
  assign inst_valid  = word.valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH_BOOT;
      hold_q  <= '{inst: NOP_INST, valid: 1'b0};
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Re-requesting the same PC leaves icache_dout stale for this cycle, so it is bubbled too.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    word    = '{inst: NOP_INST, valid: 1'b0};
    case (state_q)
      FETCH_BOOT: begin
        if (!stall) state_d = FETCH_RUN;
      end
      FETCH_RUN: begin
        word = '{inst: icache_dout, valid: 1'b1};
        if (inst_kill || (!stall && (pc_sel == PCSEL_SAME))) begin
          word = '{inst: NOP_INST, valid: 1'b0};
        end
        if (stall) begin
          hold_d  = word;
          state_d = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        word = hold_q;
        if (!stall) state_d = FETCH_RUN;
      end
      default: begin
        state_d = FETCH_BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit against a behavioural I-cache with one-cycle latency.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_sel;
  logic        inst_kill;
  logic [31:0] alu_target;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic [31:0] icache_dout;
  logic [31:0] pc_f;
  logic [31:0] inst_out;
  logic        inst_valid;

  logic [31:0] last_addr = 32'h0000_2000;
  logic [31:0] rnd_word  = 32'h0;
  logic        rnd_en    = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .pc_sel      (pc_sel),
    .inst_kill   (inst_kill),
    .alu_target  (alu_target),
    .icache_addr (icache_addr),
    .icache_re   (icache_re),
    .icache_dout (icache_dout),
    .pc_f        (pc_f),
    .inst_out    (inst_out),
    .inst_valid  (inst_valid)
  );

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    if (icache_re) last_addr <= icache_addr;
    rnd_word <= $urandom;
  end

  assign icache_dout = rnd_en ? rnd_word : inst_at(last_addr);

  typedef struct {
    logic        stall;
    logic [1:0]  sel;
    logic        kill;
    logic [31:0] tgt;
    logic        rnd;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mkv(input logic s, input logic [1:0] sel, input logic k,
                               input logic [31:0] tgt, input logic rnd,
                               input logic [31:0] ea, input logic [31:0] ep, input logic ev);
    vec_t v;
    v.stall = s; v.sel = sel; v.kill = k; v.tgt = tgt; v.rnd = rnd;
    v.e_addr = ea; v.e_pc = ep; v.e_valid = ev;
    v.e_inst = ev ? inst_at(ep) : NOP;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ea, input logic [31:0] ep,
                         input logic ev, input logic [31:0] ei);
    chk({tag, " addr"},  icache_addr, ea);
    chk({tag, " pc_f"},  pc_f, ep);
    chk({tag, " valid"}, 32'(inst_valid), 32'(ev));
    chk({tag, " inst"},  inst_out, ei);
  endtask

  vec_t vecs[23];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Boot, redirect, stall with noisy cache, redirect under stall, SAME, wrap-around.
    vecs[0]  = mkv(0, 2'd0, 0, 32'h0,        0, 32'h2000,     32'h2000,     0);
    vecs[1]  = mkv(0, 2'd0, 0, 32'h0,        0, 32'h2004,     32'h2000,     1);
    vecs[2]  = mkv(0, 2'd0, 0, 32'h0,        0, 32'h2008,     32'h2004,     1);
    vecs[3]  = mkv(0, 2'd1, 1, 32'h3003,     0, 32'h3000,     32'h2008,     0);
    vecs[4]  = mkv(0, 2'd0, 0, 32'h0,        0, 32'h3004,     32'h3000,     1);
    vecs[5]  = mkv(1, 2'd0, 0, 32'h0,        0, 32'h3004,     32'h3004,     1);
    vecs[6]  = mkv(1, 2'd0, 0, 32'h0,        1, 32'h3004,     32'h3004,     1);
    vecs[7]  = mkv(1, 2'd0, 0, 32'h0,        1, 32'h3004,     32'h3004,     1);
    vecs[8]  = mkv(0, 2'd0, 0, 32'h0,        1, 32'h3008,     32'h3004,     1);
    vecs[9]  = mkv(0, 2'd0, 0, 32'h0,        0, 32'h300C,     32'h3008,     1);
    vecs[10] = mkv(1, 2'd1, 1, 32'h4000,     0, 32'h300C,     32'h300C,     0);
    vecs[11] = mkv(1, 2'd0, 0, 32'h0,        0, 32'h300C,     32'h300C,     0);
    vecs[12] = mkv(0, 2'd0, 0, 32'h0,        0, 32'h4000,     32'h300C,     0);
    vecs[13] = mkv(0, 2'd0, 0, 32'h0,        0, 32'h4004,     32'h4000,     1);
    vecs[14] = mkv(1, 2'd1, 1, 32'h5000,     0, 32'h4004,     32'h4004,     0);
    vecs[15] = mkv(1, 2'd1, 1, 32'h6002,     0, 32'h4004,     32'h4004,     0);
    vecs[16] = mkv(0, 2'd0, 0, 32'h0,        0, 32'h6000,     32'h4004,     0);
    vecs[17] = mkv(0, 2'd0, 0, 32'h0,        0, 32'h6004,     32'h6000,     1);
    vecs[18] = mkv(0, 2'd2, 0, 32'h0,        0, 32'h6004,     32'h6004,     0);
    vecs[19] = mkv(0, 2'd0, 0, 32'h0,        0, 32'h6008,     32'h6004,     1);
    vecs[20] = mkv(0, 2'd1, 1, 32'hFFFFFFFF, 0, 32'hFFFFFFFC, 32'h6008,     0);
    vecs[21] = mkv(0, 2'd0, 0, 32'h0,        0, 32'h0000_0000, 32'hFFFFFFFC, 1);
    vecs[22] = mkv(0, 2'd0, 0, 32'h0,        0, 32'h0000_0004, 32'h0000_0000, 1);

    reset = 1'b0; stall = 1'b0; pc_sel = 2'd0; inst_kill = 1'b0; alu_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset re", 32'(icache_re), 32'd0);
    chk_all("reset", 32'h2000, 32'h2000, 1'b0, NOP);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 23; i++) begin
      stall = vecs[i].stall; pc_sel = vecs[i].sel; inst_kill = vecs[i].kill;
      alu_target = vecs[i].tgt; rnd_en = vecs[i].rnd;
      #1;
      chk($sformatf("v%0d re", i), 32'(icache_re), 32'd1);
      chk_all($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_inst);
      @(negedge clk);
    end
    rnd_en = 1'b0;

    // Queue a redirect under stall, then reset asynchronously from HOLD.
    stall = 1'b1; pc_sel = 2'd1; inst_kill = 1'b1; alu_target = 32'h7000;
    #1;
    chk_all("kill_stall", 32'h0004, 32'h0004, 1'b0, NOP);
    @(negedge clk);
    pc_sel = 2'd0; inst_kill = 1'b0; alu_target = '0;
    #1;
    chk_all("hold", 32'h0004, 32'h0004, 1'b0, NOP);
    #2 reset = 1'b0;
    #1;
    chk("mid_reset re", 32'(icache_re), 32'd0);
    chk_all("mid_reset", 32'h2000, 32'h2000, 1'b0, NOP);
    @(negedge clk);
    reset = 1'b1; stall = 1'b0;
    #1;
    chk_all("reboot0", 32'h2000, 32'h2000, 1'b0, NOP);
    @(negedge clk); #1;
    chk_all("reboot1", 32'h2004, 32'h2000, 1'b1, inst_at(32'h2000));
    @(negedge clk); #1;
    chk_all("reboot2", 32'h2008, 32'h2004, 1'b1, inst_at(32'h2004));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
